// File: rtl/uart_rx_byte_fifo.sv
// UART Rx back end: assembles voted data bits into a byte and queues it in a FWFT FIFO.
// Optional framing-error counter enabled by defining UART_RX_ERR_CNT_EN.
module uart_rx_byte_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift_rst,
  input  logic       catch_bit,
  input  logic [3:0] catch_bit_cnt,
  input  logic       i_rx_complete,
  input  logic       i_rx_error,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_full,
  output logic       o_overrun,
  input  logic       i_clr_overrun,
  output logic [7:0] o_err_cnt
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [7:0]        shadow;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              overrun;

  logic commit;
  logic pop;
  logic push;
  logic drop;

  // A simultaneous error pulse overrides completion.
  always_comb begin
    commit = i_rx_complete & ~i_rx_error;
    pop    = (count != '0) & i_ready;
    push   = commit & ((count < FULL_CNT) | pop);
    drop   = commit & ~push;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (shift_rst) begin
      shadow <= '0;
    end else if (!catch_bit_cnt[3]) begin
      shadow[catch_bit_cnt[2:0]] <= catch_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= shadow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (i_clr_overrun) begin
      overrun <= 1'b0;
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (i_rx_error && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign o_err_cnt = err_cnt;
`else
  assign o_err_cnt = '0;
`endif

  assign o_data    = mem[rd_ptr];
  assign o_valid   = (count != '0);
  assign o_full    = (count == FULL_CNT);
  assign o_overrun = overrun;

endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
// Directed bench for uart_rx_byte_fifo: stimulus pushes expected bytes into a queue,
// a monitor pops and compares on every accepted handshake.
module tb_uart_rx_byte_fifo;

`ifdef UART_RX_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       shift_rst;
  logic       catch_bit;
  logic [3:0] catch_bit_cnt;
  logic       i_rx_complete;
  logic       i_rx_error;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_full;
  logic       o_overrun;
  logic       i_clr_overrun;
  logic [7:0] o_err_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_byte_fifo #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .shift_rst    (shift_rst),
    .catch_bit    (catch_bit),
    .catch_bit_cnt(catch_bit_cnt),
    .i_rx_complete(i_rx_complete),
    .i_rx_error   (i_rx_error),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_full       (o_full),
    .o_overrun    (o_overrun),
    .i_clr_overrun(i_clr_overrun),
    .o_err_cnt    (o_err_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Monitor: every accepted byte must match the head of the expected queue.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got %02h expected none", o_data);
        end else begin
          e = exp_q.pop_front();
          check("pop_data", o_data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // One frame: clear, 8 data bits LSB first, two out-of-range indices, then the pulse(s).
  task automatic send_frame(input logic [7:0] b, input bit cmp, input bit err,
                            input bit rdy, input bit clr);
    shift_rst = 1'b1;
    tick;
    shift_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      catch_bit_cnt = 4'(i);
      catch_bit     = b[i];
      tick;
    end
    catch_bit_cnt = 4'd8;
    catch_bit     = ~b[0];
    tick;
    catch_bit_cnt = 4'd15;
    catch_bit     = ~b[7];
    tick;
    i_rx_complete = cmp;
    i_rx_error    = err;
    i_ready       = rdy;
    i_clr_overrun = clr;
    tick;
    i_rx_complete = 1'b0;
    i_rx_error    = 1'b0;
    i_ready       = 1'b0;
    i_clr_overrun = 1'b0;
    shift_rst     = 1'b1;
    catch_bit_cnt = 4'd0;
  endtask

  task automatic drain;
    i_ready = 1'b1;
    for (int n = 0; n < 12 && o_valid; n++) tick;
    i_ready = 1'b0;
    check("drain_empty", {7'b0, o_valid}, 8'h00);
    check("drain_q_empty", 8'(exp_q.size()), 8'h00);
  endtask

  initial begin
    rst_n         = 1'b0;
    shift_rst     = 1'b1;
    catch_bit     = 1'b0;
    catch_bit_cnt = 4'd0;
    i_rx_complete = 1'b0;
    i_rx_error    = 1'b0;
    i_ready       = 1'b0;
    i_clr_overrun = 1'b0;
    #12 rst_n = 1'b1;
    tick;

    check("rst_valid",   {7'b0, o_valid},   8'h00);
    check("rst_full",    {7'b0, o_full},    8'h00);
    check("rst_overrun", {7'b0, o_overrun}, 8'h00);
    check("rst_err_cnt", o_err_cnt,         8'h00);

    // Frame assembly and single pop
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'hA5);
    check("a5_valid", {7'b0, o_valid}, 8'h01);
    check("a5_data",  o_data,          8'hA5);
    i_ready = 1'b1;
    tick;
    i_ready = 1'b0;
    check("a5_popped", {7'b0, o_valid}, 8'h00);

    // Error discard, simultaneous pulses, saturation
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    check("err_valid", {7'b0, o_valid}, 8'h00);
    check("err_cnt1",  o_err_cnt, ERR_EN ? 8'h01 : 8'h00);
    send_frame(8'h77, 1'b1, 1'b1, 1'b0, 1'b0);
    check("both_valid", {7'b0, o_valid}, 8'h00);
    check("err_cnt2",   o_err_cnt, ERR_EN ? 8'h02 : 8'h00);
    i_rx_error = 1'b1;
    repeat (254) tick;
    i_rx_error = 1'b0;
    tick;
    check("err_cnt_sat", o_err_cnt, ERR_EN ? 8'hFF : 8'h00);

    // Fill and overrun
    for (int v = 1; v <= 9; v++) begin
      send_frame(8'(v), 1'b1, 1'b0, 1'b0, 1'b0);
      if (v <= 8) exp_q.push_back(8'(v));
      if (v == 8) begin
        check("fill_full8",    {7'b0, o_full},    8'h01);
        check("fill_overrun8", {7'b0, o_overrun}, 8'h00);
      end
    end
    check("ovr_full",    {7'b0, o_full},    8'h01);
    check("ovr_set",     {7'b0, o_overrun}, 8'h01);
    send_frame(8'h0A, 1'b1, 1'b0, 1'b0, 1'b1);
    check("ovr_set_prio", {7'b0, o_overrun}, 8'h01);
    drain();
    check("ovr_still", {7'b0, o_overrun}, 8'h01);
    i_clr_overrun = 1'b1;
    tick;
    i_clr_overrun = 1'b0;
    check("ovr_clr", {7'b0, o_overrun}, 8'h00);

    // Full with simultaneous pop
    for (int v = 8'h11; v <= 8'h18; v++) begin
      send_frame(8'(v), 1'b1, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(8'(v));
    end
    check("fp_full", {7'b0, o_full}, 8'h01);
    send_frame(8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(8'h55);
    check("fp_full_after", {7'b0, o_full},    8'h01);
    check("fp_no_overrun", {7'b0, o_overrun}, 8'h00);
    drain();

    // Wrap-around
    for (int v = 0; v < 20; v++) begin
      send_frame(8'(v), 1'b1, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(8'(v));
      check("wrap_not_full", {7'b0, o_full}, 8'h00);
      i_ready = 1'b1;
      tick;
      i_ready = 1'b0;
    end
    check("wrap_empty", {7'b0, o_valid}, 8'h00);

    // Reset mid-operation: overrun set, 3 bytes queued, partial shadow 8'h0F
    for (int v = 8'h21; v <= 8'h29; v++) begin
      send_frame(8'(v), 1'b1, 1'b0, 1'b0, 1'b0);
      if (v <= 8'h28) exp_q.push_back(8'(v));
    end
    check("pre_rst_overrun", {7'b0, o_overrun}, 8'h01);
    i_ready = 1'b1;
    repeat (5) tick;
    i_ready = 1'b0;
    check("pre_rst_queued", 8'(exp_q.size()), 8'h03);
    shift_rst = 1'b1;
    tick;
    shift_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      catch_bit_cnt = 4'(i);
      catch_bit     = 1'b1;
      tick;
    end
    catch_bit_cnt = 4'd15;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("mid_rst_valid",   {7'b0, o_valid},   8'h00);
    check("mid_rst_overrun", {7'b0, o_overrun}, 8'h00);
    check("mid_rst_full",    {7'b0, o_full},    8'h00);
    check("mid_rst_err_cnt", o_err_cnt,         8'h00);
    #2 rst_n = 1'b1;
    exp_q.delete();
    tick;

    // Without shift_rst, only the upper nibble is written; reset must have cleared the lower one
    for (int i = 4; i < 8; i++) begin
      catch_bit_cnt = 4'(i);
      catch_bit     = 1'b1;
      tick;
    end
    catch_bit_cnt = 4'd15;
    i_rx_complete = 1'b1;
    tick;
    i_rx_complete = 1'b0;
    shift_rst     = 1'b1;
    exp_q.push_back(8'hF0);
    check("post_rst_valid", {7'b0, o_valid}, 8'h01);
    check("post_rst_data",  o_data,          8'hF0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
